// File: rtl/lsu_mem_stage.sv
// RV32I load/store unit between EX and a word-wide req/ack data memory.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of forcing alignment.
module lsu_mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       off_q, off_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [3:0]       mem_wstrb_q, mem_wstrb_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;

  logic             f3_ok;
  logic [1:0]       off_eff;
  logic [3:0]       strb_new;
  logic [31:0]      wdata_new;
  logic [31:0]      load_ext;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout_hit;

  // Decode request: lane offset (low bits forced to the access size), strobes, replicated data
  always_comb begin
    f3_ok     = 1'b0;
    off_eff   = addr[1:0];
    strb_new  = 4'b0000;
    wdata_new = wdata;
    case (funct3)
      F3_B, F3_BU: begin
        f3_ok     = 1'b1;
        strb_new  = 4'b0001 << off_eff;
        wdata_new = {4{wdata[7:0]}};
      end
      F3_H, F3_HU: begin
        f3_ok     = 1'b1;
        off_eff   = {addr[1], 1'b0};
        strb_new  = 4'b0011 << off_eff;
        wdata_new = {2{wdata[15:0]}};
      end
      F3_W: begin
        f3_ok     = 1'b1;
        off_eff   = 2'b00;
        strb_new  = 4'b1111;
      end
      default: f3_ok = 1'b0;
    endcase
    if (!we) strb_new = 4'b0000;
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = (((funct3 == F3_H) || (funct3 == F3_HU)) && addr[0]) ||
                    ((funct3 == F3_W) && (addr[1:0] != 2'b00));
`endif

  // Extract and extend the addressed lane of the returned word
  always_comb begin
    case (off_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      F3_B:    load_ext = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   load_ext = {24'd0, ld_byte};
      F3_H:    load_ext = {{16{ld_half[15]}}, ld_half};
      F3_HU:   load_ext = {16'd0, ld_half};
      default: load_ext = mem_rdata;
    endcase
  end

  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    f3_d        = f3_q;
    off_d       = off_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    rdata_d     = rdata_q;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!f3_ok) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
`ifdef LSU_MISALIGN_TRAP_EN
          else if (misalign) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
`endif
          else begin
            state_d     = S_REQ;
            cnt_d       = '0;
            we_d        = we;
            f3_d        = funct3;
            off_d       = off_eff;
            mem_req_d   = 1'b1;
            mem_we_d    = we;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_wstrb_d = strb_new;
            mem_wdata_d = wdata_new;
          end
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          if (!we_q) rdata_d = load_ext;
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
          if (timeout_hit) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            mem_req_d = 1'b1;
            mem_we_d  = we_q;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wstrb_q <= 4'b0000;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_wdata = mem_wdata_q;

endmodule
